// File: rtl/pcc_rr_connection_arbiter.sv
// Round-robin circuit-setup arbiter for the 4-port PCC router crossbar.
// It holds the connection matrix and tears connections down on strobe drop, fail/cancel or idle timeout.
module pcc_rr_connection_arbiter #(
    parameter int                  PORTS    = 4,
    parameter int                  DESTW    = 2,
    parameter int                  TIMEOUTW = 8,
    parameter logic [TIMEOUTW-1:0] TIMEOUT  = 8'd255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PORTS-1:0]         req_i,
    input  logic [PORTS*DESTW-1:0]   req_dest_i,
    input  logic [PORTS-1:0]         stb_i,
    input  logic [PORTS-1:0]         fwd_i,
    input  logic [PORTS-1:0]         out_fail_i,
    input  logic [PORTS-1:0]         out_cancel_i,
    output logic [PORTS-1:0]         grant_o,
    output logic [PORTS-1:0]         deny_o,
    output logic [PORTS-1:0]         timeout_o,
    output logic [PORTS*PORTS-1:0]   connections_o,
    output logic [PORTS-1:0]         occupied_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONN = 1'b1
    } conn_state_e;

    localparam logic [TIMEOUTW-1:0] WD_LAST = TIMEOUT - 1'b1;

    conn_state_e          state_q [PORTS];
    conn_state_e          state_d [PORTS];
    logic [DESTW-1:0]     dest_q  [PORTS];
    logic [DESTW-1:0]     dest_d  [PORTS];
    logic [TIMEOUTW-1:0]  wd_q    [PORTS];
    logic [TIMEOUTW-1:0]  wd_d    [PORTS];
    logic [DESTW-1:0]     rr_q    [PORTS];
    logic [DESTW-1:0]     rr_d    [PORTS];
    logic [DESTW-1:0]     req_dest [PORTS];
    logic [PORTS-1:0]     eligible;
    logic [PORTS-1:0]     grant_d, deny_d, timeout_d, occ_d;
    logic [PORTS*PORTS-1:0] conn_d;

    always_comb begin : decode
        for (int n = 0; n < PORTS; n++) begin
            req_dest[n] = req_dest_i[n*DESTW +: DESTW];
            eligible[n] = (state_q[n] == S_IDLE) && req_i[n];
        end
    end

    always_comb begin : next_state
        logic [DESTW-1:0] idx;
        logic             found;
        logic             release_ext;
        grant_d     = '0;
        deny_d      = '0;
        timeout_d   = '0;
        idx         = '0;
        found       = 1'b0;
        release_ext = 1'b0;
        for (int n = 0; n < PORTS; n++) begin
            state_d[n] = state_q[n];
            dest_d[n]  = dest_q[n];
            wd_d[n]    = wd_q[n];
            rr_d[n]    = rr_q[n];
        end
        for (int n = 0; n < PORTS; n++) begin
            if (state_q[n] == S_CONN) begin
                release_ext = !stb_i[n] || out_fail_i[dest_q[n]] || out_cancel_i[dest_q[n]];
                if (release_ext) begin
                    state_d[n] = S_IDLE;
                    wd_d[n]    = '0;
                end else if (fwd_i[n]) begin
                    wd_d[n] = '0;
                end else if (wd_q[n] == WD_LAST) begin
                    state_d[n]   = S_IDLE;
                    wd_d[n]      = '0;
                    timeout_d[n] = 1'b1;
                end else begin
                    wd_d[n] = wd_q[n] + 1'b1;
                end
            end
        end
        // Arbitration uses the registered occupancy, so a same-cycle release still denies.
        for (int o = 0; o < PORTS; o++) begin
            found = 1'b0;
            for (int k = 0; k < PORTS; k++) begin
                idx = rr_q[o] + DESTW'(k);
                if (eligible[idx] && (req_dest[idx] == DESTW'(o))) begin
                    if (occupied_o[o] || found) begin
                        deny_d[idx] = 1'b1;
                    end else begin
                        found          = 1'b1;
                        grant_d[idx]   = 1'b1;
                        state_d[idx]   = S_CONN;
                        dest_d[idx]    = DESTW'(o);
                        wd_d[idx]      = '0;
                        rr_d[o]        = idx + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin : matrix
        conn_d = '0;
        occ_d  = '0;
        for (int o = 0; o < PORTS; o++) begin
            for (int n = 0; n < PORTS; n++) begin
                if ((state_d[n] == S_CONN) && (dest_d[n] == DESTW'(o))) begin
                    conn_d[o*PORTS+n] = 1'b1;
                    occ_d[o]          = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < PORTS; n++) begin
                state_q[n] <= S_IDLE;
                dest_q[n]  <= '0;
                wd_q[n]    <= '0;
                rr_q[n]    <= '0;
            end
            grant_o       <= '0;
            deny_o        <= '0;
            timeout_o     <= '0;
            connections_o <= '0;
            occupied_o    <= '0;
        end else begin
            for (int n = 0; n < PORTS; n++) begin
                state_q[n] <= state_d[n];
                dest_q[n]  <= dest_d[n];
                wd_q[n]    <= wd_d[n];
                rr_q[n]    <= rr_d[n];
            end
            grant_o       <= grant_d;
            deny_o        <= deny_d;
            timeout_o     <= timeout_d;
            connections_o <= conn_d;
            occupied_o    <= occ_d;
        end
    end

endmodule

// File: tb/tb_pcc_rr_connection_arbiter.sv
// Directed bench for pcc_rr_connection_arbiter, built with a 4-cycle watchdog.
// Each step drives inputs, advances one edge, and checks the registered outputs.
module tb_pcc_rr_connection_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_i, stb_i, fwd_i, out_fail_i, out_cancel_i;
    logic [7:0]  req_dest_i;
    logic [3:0]  grant_o, deny_o, timeout_o, occupied_o;
    logic [15:0] connections_o;

    int n_cmp = 0;
    int n_err = 0;

    pcc_rr_connection_arbiter #(
        .PORTS(4), .DESTW(2), .TIMEOUTW(8), .TIMEOUT(8'd4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_i(req_i), .req_dest_i(req_dest_i), .stb_i(stb_i), .fwd_i(fwd_i),
        .out_fail_i(out_fail_i), .out_cancel_i(out_cancel_i),
        .grant_o(grant_o), .deny_o(deny_o), .timeout_o(timeout_o),
        .connections_o(connections_o), .occupied_o(occupied_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL time_limit: observed run still active, expected finish");
        $fatal(1, "time limit");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pulses(input string tag, input logic [3:0] g, input logic [3:0] d,
                                input logic [3:0] t);
        check({tag, ".grant"}, 32'(grant_o), 32'(g));
        check({tag, ".deny"}, 32'(deny_o), 32'(d));
        check({tag, ".timeout"}, 32'(timeout_o), 32'(t));
    endtask

    task automatic check_matrix(input string tag, input logic [15:0] c, input logic [3:0] occ);
        check({tag, ".conn"}, 32'(connections_o), 32'(c));
        check({tag, ".occ"}, 32'(occupied_o), 32'(occ));
    endtask

    int          order [6] = '{0, 1, 3, 0, 1, 3};
    logic [3:0]  w_mask;

    initial begin
        reset = 1'b1;
        req_i = '0; req_dest_i = '0; stb_i = '0; fwd_i = 4'hF;
        out_fail_i = '0; out_cancel_i = '0;
        tick();
        tick();
        check_pulses("reset", 4'h0, 4'h0, 4'h0);
        check_matrix("reset", 16'h0000, 4'h0);
        reset = 1'b0;

        // single grant: input 0 -> output 2
        req_i = 4'b0001; req_dest_i = 8'h02; stb_i = 4'b0001;
        tick();
        check_pulses("single.grant_cyc", 4'b0001, 4'h0, 4'h0);
        check_matrix("single.grant_cyc", 16'h0100, 4'b0100);
        req_i = '0;
        tick();
        check_pulses("single.hold", 4'h0, 4'h0, 4'h0);
        check_matrix("single.hold", 16'h0100, 4'b0100);
        stb_i = '0;
        tick();
        check_matrix("single.release", 16'h0000, 4'h0);

        // round robin: inputs 0,1,3 contend for output 1
        req_i = 4'b1011; req_dest_i = 8'h45;
        for (int i = 0; i < 6; i++) begin
            w_mask = 4'b0001 << order[i];
            stb_i = 4'b1011;
            tick();
            check_pulses($sformatf("rr.grant%0d", i), w_mask, 4'b1011 & ~w_mask, 4'h0);
            check_matrix($sformatf("rr.grant%0d", i), 16'h0001 << (4 + order[i]), 4'b0010);
            stb_i = 4'b1011 & ~w_mask;
            tick();
            check_pulses($sformatf("rr.busy%0d", i), 4'h0, 4'b1011 & ~w_mask, 4'h0);
            check_matrix($sformatf("rr.busy%0d", i), 16'h0000, 4'h0);
        end
        req_i = '0; stb_i = '0;
        tick();

        // occupied deny and cancel
        req_i = 4'b0100; req_dest_i = 8'h00; stb_i = 4'b0100;
        tick();
        check_pulses("occ.hold_grant", 4'b0100, 4'h0, 4'h0);
        check_matrix("occ.hold_grant", 16'h0004, 4'b0001);
        req_i = 4'b0010; stb_i = 4'b0110;
        tick();
        check_pulses("occ.deny", 4'h0, 4'b0010, 4'h0);
        check_matrix("occ.deny", 16'h0004, 4'b0001);
        out_cancel_i = 4'b0001;
        tick();
        check_pulses("occ.cancel_edge", 4'h0, 4'b0010, 4'h0);
        check_matrix("occ.cancel_edge", 16'h0000, 4'h0);
        out_cancel_i = '0;
        tick();
        check_pulses("occ.regrant", 4'b0010, 4'h0, 4'h0);
        check_matrix("occ.regrant", 16'h0002, 4'b0001);
        req_i = '0; stb_i = '0;
        tick();
        check_matrix("occ.clear", 16'h0000, 4'h0);

        // watchdog: input 3 -> output 2, idle until timeout
        fwd_i = 4'b0111; req_i = 4'b1000; req_dest_i = 8'h80; stb_i = 4'b1000;
        tick();
        check_pulses("wd.grant", 4'b1000, 4'h0, 4'h0);
        check_matrix("wd.grant", 16'h0800, 4'b0100);
        req_i = '0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_pulses($sformatf("wd.idle%0d", c), 4'h0, 4'h0, 4'h0);
            check_matrix($sformatf("wd.idle%0d", c), 16'h0800, 4'b0100);
        end
        tick();
        check_pulses("wd.expire", 4'h0, 4'h0, 4'b1000);
        check_matrix("wd.expire", 16'h0000, 4'h0);
        tick();
        check_pulses("wd.after", 4'h0, 4'h0, 4'h0);

        // watchdog kept alive by fwd every third cycle
        req_i = 4'b1000;
        tick();
        check_pulses("wdfwd.grant", 4'b1000, 4'h0, 4'h0);
        req_i = '0;
        for (int c = 1; c <= 12; c++) begin
            fwd_i = (c % 3 == 0) ? 4'b1111 : 4'b0111;
            tick();
            check($sformatf("wdfwd.timeout%0d", c), 32'(timeout_o), 32'h0);
            check($sformatf("wdfwd.conn%0d", c), 32'(connections_o), 32'h0800);
        end
        fwd_i = 4'hF; stb_i = '0;
        tick();
        check_matrix("wdfwd.release", 16'h0000, 4'h0);

        // simultaneous: 0->1, 1->2, 2->3, 3->0
        req_i = 4'b1111; req_dest_i = 8'h39; stb_i = 4'b1111;
        tick();
        check_pulses("sim.grant", 4'b1111, 4'h0, 4'h0);
        check_matrix("sim.grant", 16'h4218, 4'b1111);
        req_i = '0; out_fail_i = 4'b0110;
        tick();
        check_matrix("sim.fail_two", 16'h4008, 4'b1001);
        tick();
        check_matrix("sim.fail_unocc", 16'h4008, 4'b1001);
        out_fail_i = '0;

        // third connection, then asynchronous reset between edges
        req_i = 4'b0001; req_dest_i = 8'h01; stb_i = 4'b1101;
        tick();
        check_pulses("rst.third", 4'b0001, 4'h0, 4'h0);
        check_matrix("rst.third", 16'h4018, 4'b1011);
        req_i = '0;
        #2;
        reset = 1'b1;
        #1;
        check_pulses("rst.async", 4'h0, 4'h0, 4'h0);
        check_matrix("rst.async", 16'h0000, 4'h0);
        tick();
        reset = 1'b0;
        stb_i = '0;
        tick();
        check_matrix("rst.quiet", 16'h0000, 4'h0);

        // pointers back at 0: input 0 beats input 3 on output 1
        req_i = 4'b1001; req_dest_i = 8'h41; stb_i = 4'b1001;
        tick();
        check_pulses("rst.rr1", 4'b0001, 4'b1000, 4'h0);
        check_matrix("rst.rr1", 16'h0010, 4'b0010);
        // output 0 from inputs 1 and 2: pointer 0 picks input 1
        req_i = 4'b0110; req_dest_i = 8'h00; stb_i = 4'b0111;
        tick();
        check_pulses("rst.rr0", 4'b0010, 4'b0100, 4'h0);
        check_matrix("rst.rr0", 16'h0012, 4'b0011);
        req_i = '0; stb_i = '0;
        tick();
        check_matrix("end.clear", 16'h0000, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pcc_rr_connection_arbiter.md
# pcc_rr_connection_arbiter

Round-robin connection arbiter for the 4-port packet-connected-circuit (PCC) router. It replaces the fixed-priority select and decode path in front of the crossbar. Each cycle it arbitrates circuit-setup requests from the input FSMs against the current output-port occupancy and holds the resulting crossbar connection matrix. It tears connections down on input strobe release, on downstream fail/cancel, or on an idle watchdog timeout.

## Interface
- PORTS, 4, number of input and output ports (fixed at 4 for this block).
- DESTW, 2, width of the encoded destination port index.
- TIMEOUTW, 8, width of the per-connection idle watchdog counter.
- TIMEOUT, 8'd255, count of idle cycles (stb high, fwd low) before forced teardown.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_i  in  4  per-input circuit-setup request, level, sampled each cycle.
- req_dest_i  in  8  per-input destination index; bits [2n+1:2n] belong to input n.
- stb_i  in  4  per-input strobe; a connection is held while high.
- fwd_i  in  4  per-input forward-activity flag; resets the watchdog.
- out_fail_i  in  4  per-output fail from the output FSM; releases that output.
- out_cancel_i  in  4  per-output cancel from the output FSM; releases that output.
- grant_o  out  4  one-cycle grant pulse per input.
- deny_o  out  4  one-cycle deny pulse per input.
- timeout_o  out  4  one-cycle pulse per input on watchdog teardown.
- connections_o  out  16  crossbar matrix; bit 4*out+in set means input in drives output out.
- occupied_o  out  4  per-output busy flag (OR of that output's connection row).

## Operation
- Per-input state: IDLE or CONNECTED. The block holds conn_dest[n] (2b) and wd_cnt[n] (TIMEOUTW b).
- Per-output round-robin pointer rr[o] (2b), reset to 0.
- Requests: an input is eligible when it is IDLE and req_i[n]=1. Requests from CONNECTED inputs are ignored (no grant, no deny).
- For each output o, candidates are the eligible inputs whose dest==o.
  - If occupied_o[o]=1 (registered value), every candidate gets deny.
  - Otherwise the winner is the first candidate at or after rr[o], scanning upward modulo 4. The winner gets grant and goes IDLE->CONNECTED with conn_dest=o. Every other candidate gets deny. Then rr[o] <= winner+1 mod 4.
- Loopback (dest == own index) is legal.
- Release: a CONNECTED input n returns to IDLE when any of these holds:
  - stb_i[n]=0;
  - out_fail_i[conn_dest[n]]=1;
  - out_cancel_i[conn_dest[n]]=1;
  - the watchdog expires.
- Watchdog: wd_cnt clears on grant and whenever fwd_i[n]=1 while CONNECTED. Otherwise it increments while CONNECTED. When wd_cnt==TIMEOUT-1 on an idle cycle, the input releases and timeout_o[n] pulses.
- Fail/cancel asserted on an unoccupied output: no effect.
- Release and a new request to the same output in the same cycle: the request sees the old occupancy and is denied.
- Reset mid-connection: all state clears immediately. Connections and occupied go to 0, pointers go to 0, pulses go to 0.

## Timing
- All outputs are registered. Reset values: grant_o=0, deny_o=0, timeout_o=0, connections_o=16'h0, occupied_o=4'h0.
- Request sampled at edge t produces grant/deny, connections_o and occupied_o at t+1 (latency 1).
- Release condition sampled at t clears the connection bits and occupied at t+1. A request to that output sampled at t+1 can be granted at t+2.
- grant_o, deny_o and timeout_o are strictly single-cycle pulses. A held req_i on a denied input re-arbitrates every cycle and produces repeated deny pulses.
- For any input, grant_o, deny_o and timeout_o are mutually exclusive in a cycle.
- Invariant: each row and each column of the connection matrix has at most one bit set.

## Test plan
- Single grant: reset, then req_i=4'b0001 with dest0=2 for one cycle. Next cycle grant_o=4'b0001, connections_o bit 8 set, occupied_o=4'b0100. Drop stb_i[0]; one cycle later connections_o=0 and occupied_o=0.
- Round-robin fairness: inputs 0,1,3 all request output 1 repeatedly, each releasing one cycle after its grant. Grant order is 0,1,3,0,1,3, and the losers get a deny every arbitration cycle.
- Occupied deny: input 2 holds output 0. Input 1 requests dest 0, producing deny_o=4'b0010 and no change to connections_o. Assert out_cancel_i[0]; input 2 releases, and input 1's re-request is granted two cycles after the cancel.
- Watchdog: with TIMEOUT=4, grant input 3 and hold stb high with fwd low. timeout_o[3] pulses 4 cycles after the grant and the connection clears. Repeat with fwd pulsing every 3 cycles: no timeout occurs.
- Simultaneous: all 4 inputs request distinct outputs in the same cycle. All four are granted and connections_o is a permutation matrix. Assert out_fail_i on two of those outputs in the same cycle: both clear together.
- Reset mid-operation: with 3 connections active, assert reset asynchronously between clock edges. All outputs go to 0 immediately. After release, a new request to output 0 gets its grant under pointer rr=0.
